// File: rtl/bcd_pulse_pkg.sv
// Package: bcd_pulse_pkg
// Shared types and helpers for the BCD pulse emitter.
//   state_t     - emitter FSM states (IDLE, PULSE, GAP, DONE)
//   bcd_digit_t - one BCD digit
//   BCD_MAX     - largest legal BCD digit value
//   bcd_valid4  - true when all four digits of a 16-bit BCD word are 0..9
package bcd_pulse_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PULSE = 2'd1,
      GAP   = 2'd2,
      DONE  = 2'd3
   } state_t;

   typedef logic [3:0] bcd_digit_t;

   localparam bcd_digit_t BCD_MAX = 4'd9;

   function automatic logic bcd_valid4(input logic [15:0] value);
      logic ok;
      ok = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (value[i*4 +: 4] > BCD_MAX) ok = 1'b0;
      end
      return ok;
   endfunction

endpackage

// File: rtl/bcd_down_counter.sv
// Module: bcd_down_counter
// Four-digit BCD register that counts down by one with a digit borrow chain.
// Ports:
//   clk, reset  - clock, asynchronous active-high reset (clears to 0000)
//   load        - load load_value (takes priority over dec)
//   load_value  - 16-bit BCD value to load, [15:12] most significant
//   dec         - decrement by one; ignored when the count is already zero
//   value       - current BCD count
//   is_zero     - value == 0000
module bcd_down_counter
   import bcd_pulse_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic [15:0] load_value,
   input  logic        dec,
   output logic [15:0] value,
   output logic        is_zero
);

   bcd_digit_t digit_reg  [4];
   bcd_digit_t digit_next [4];
   // borrow[i] means digit i must step down this cycle.
   logic [3:0] borrow;

   // Gating with is_zero keeps the count from wrapping to 9999.
   assign borrow[0] = dec & ~is_zero;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_digit
         if (gi < 3) begin : g_chain
            // A digit sitting at 0 wraps to 9 and passes the borrow upward.
            assign borrow[gi+1] = borrow[gi] & (digit_reg[gi] == 4'd0);
         end

         assign digit_next[gi] = load       ? load_value[gi*4 +: 4] :
                                 borrow[gi] ? ((digit_reg[gi] == 4'd0) ? BCD_MAX
                                                                       : digit_reg[gi] - 4'd1) :
                                              digit_reg[gi];

         assign value[gi*4 +: 4] = digit_reg[gi];
      end
   endgenerate

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < 4; i++) digit_reg[i] <= '0;
      end else begin
         for (int i = 0; i < 4; i++) digit_reg[i] <= digit_next[i];
      end
   end

   assign is_zero = (value == 16'h0000);

endmodule

// File: rtl/bcd_pulse_emitter.sv
// Module: bcd_pulse_emitter
// Emits exactly N evenly spaced pulses, where N is a 4-digit BCD request,
// counting the remaining pulses down in BCD for a seven-segment display.
// Parameters:
//   TICK_DIV   - pulse period in clk cycles (must exceed PULSE_HIGH)
//   PULSE_HIGH - pulse width in clk cycles (1 or more)
// Ports:
//   clk, reset - clock, asynchronous active-high reset
//   start      - run request, sampled only in IDLE
//   abort      - stops an active run on the next edge (beats start)
//   bcd_in     - requested pulse count, 4 BCD digits
//   pulse_out  - pulse train
//   busy       - run in progress (PULSE, GAP, DONE)
//   done       - one-cycle strobe on normal completion
//   err        - one-cycle strobe when start carries a non-BCD digit
//   remaining  - BCD pulses still to emit
//   sent       - binary pulses emitted this run
// Configuration macro:
//   BCD_PULSE_SENT_EN - when defined the binary sent counter is built;
//                       otherwise sent is tied to 0.
module bcd_pulse_emitter
   import bcd_pulse_pkg::*;
#(
   parameter int TICK_DIV   = 100000,
   parameter int PULSE_HIGH = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        abort,
   input  logic [15:0] bcd_in,
   output logic        pulse_out,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] remaining,
   output logic [15:0] sent
);

   localparam int CNT_W = $clog2(TICK_DIV + 1);
   // Terminal counts: the counter restarts at 0 on every PULSE/GAP entry.
   localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_HIGH - 1);
   localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(TICK_DIV - PULSE_HIGH - 1);

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] cnt_reg, cnt_next;
   logic             load, dec;
   logic [15:0]      remaining_value;
   logic             remaining_is_zero;

   logic pulse_out_reg, pulse_out_next;
   logic busy_reg, busy_next;
   logic done_reg, done_next;
   logic err_reg, err_next;

   bcd_down_counter u_counter (
      .clk        (clk),
      .reset      (reset),
      .load       (load),
      .load_value (bcd_in),
      .dec        (dec),
      .value      (remaining_value),
      .is_zero    (remaining_is_zero)
   );

   // State, tick counter and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg     <= IDLE;
         cnt_reg       <= '0;
         pulse_out_reg <= 1'b0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
         err_reg       <= 1'b0;
      end else begin
         state_reg     <= state_next;
         cnt_reg       <= cnt_next;
         pulse_out_reg <= pulse_out_next;
         busy_reg      <= busy_next;
         done_reg      <= done_next;
         err_reg       <= err_next;
      end
   end

   // Next-state logic, also producing the counter load/decrement controls.
   always_comb begin
      state_next = state_reg;
      load       = 1'b0;
      dec        = 1'b0;
      case (state_reg)
         IDLE: begin
            if (start && !abort && bcd_valid4(bcd_in)) begin
               if (bcd_in == 16'h0000) begin
                  state_next = DONE;
               end else begin
                  load       = 1'b1;
                  state_next = PULSE;
               end
            end
         end
         PULSE: begin
            if (abort) begin
               state_next = IDLE;
            end else if (cnt_reg == PULSE_LAST) begin
               dec = !remaining_is_zero;
               // The count about to reach zero means this was the final pulse.
               state_next = (remaining_value == 16'h0001) ? DONE : GAP;
            end
         end
         GAP: begin
            if (abort) state_next = IDLE;
            else if (cnt_reg == GAP_LAST) state_next = PULSE;
         end
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output logic: outputs are computed from the upcoming state and
   // registered, so each output lines up with the state it describes.
   always_comb begin
      pulse_out_next = (state_next == PULSE);
      busy_next      = (state_next != IDLE);
      done_next      = (state_next == DONE);
      err_next       = (state_reg == IDLE) && start && !abort && !bcd_valid4(bcd_in);
      if (state_next != state_reg) cnt_next = '0;
      else if (state_reg == PULSE || state_reg == GAP) cnt_next = cnt_reg + CNT_W'(1);
      else cnt_next = '0;
   end

`ifdef BCD_PULSE_SENT_EN
   logic [15:0] sent_reg;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)     sent_reg <= '0;
      else if (load) sent_reg <= '0;
      else if (dec)  sent_reg <= sent_reg + 16'd1;
   end

   assign sent = sent_reg;
`else
   assign sent = '0;
`endif

   assign pulse_out = pulse_out_reg;
   assign busy      = busy_reg;
   assign done      = done_reg;
   assign err       = err_reg;
   assign remaining = remaining_value;

endmodule

// File: tb/tb_bcd_pulse_emitter.sv
module tb_bcd_pulse_emitter;

   localparam int TD = 8;
   localparam int PH = 2;
`ifdef BCD_PULSE_SENT_EN
   localparam bit SENT_EN = 1'b1;
`else
   localparam bit SENT_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [15:0] bcd_in = 16'h0000;
   logic        pulse_out, busy, done, err;
   logic [15:0] remaining, sent;

   int n_tests = 0;
   int n_fail  = 0;

   bcd_pulse_emitter #(.TICK_DIV(TD), .PULSE_HIGH(PH)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .abort     (abort),
      .bcd_in    (bcd_in),
      .pulse_out (pulse_out),
      .busy      (busy),
      .done      (done),
      .err       (err),
      .remaining (remaining),
      .sent      (sent)
   );

   always #5 clk = ~clk;

   // Reference model helpers: plain decimal arithmetic.
   function automatic logic [15:0] to_bcd(input int d);
      return {4'((d / 1000) % 10), 4'((d / 100) % 10), 4'((d / 10) % 10), 4'(d % 10)};
   endfunction

   function automatic int from_bcd(input logic [15:0] v);
      return v[15:12] * 1000 + v[11:8] * 100 + v[7:4] * 10 + v[3:0];
   endfunction

   // Pulse j (1-based) is high in cycles (j-1)*TD+1 .. (j-1)*TD+PH after the start edge.
   function automatic logic model_pulse(input int n, input int c);
      return (c >= 1) && (c <= (n - 1) * TD + PH) && (((c - 1) % TD) < PH);
   endfunction

   // Pulses whose last high cycle lies before cycle c.
   function automatic int model_done_pulses(input int n, input int c);
      int k;
      k = (c <= PH) ? 0 : ((c - PH - 1) / TD) + 1;
      return (k > n) ? n : k;
   endfunction

   // Presents a request so it is sampled at the next edge (edge 0); returns in cycle 1.
   task automatic start_run(input logic [15:0] v);
      @(posedge clk); #1;
      bcd_in = v;
      start  = 1'b1;
      @(posedge clk); #1;
      start  = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if ({pulse_out, busy, done, err} !== 4'b0000 || remaining !== 16'h0 || sent !== 16'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: pulse=%b busy=%b done=%b err=%b rem=%h sent=%h, required all 0",
                  pulse_out, busy, done, err, remaining, sent);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
      n_tests++;
      if ({pulse_out, busy, done, err} !== 4'b0000) begin
         n_fail++;
         $display("FAIL reset_idle: pulse=%b busy=%b done=%b err=%b, required 0000",
                  pulse_out, busy, done, err);
      end
      $display("[TB] reset: outputs checked");
   endtask

   // Full run of n pulses, checked cycle by cycle through one idle cycle after done.
   task automatic test_run(input int n);
      int last;
      int k;
      int errs;
      errs = 0;
      last = (n - 1) * TD + PH + 1;
      start_run(to_bcd(n));
      for (int c = 1; c <= last + 1; c++) begin
         @(negedge clk);
         k = model_done_pulses(n, c);
         n_tests++;
         if (pulse_out !== model_pulse(n, c) || done !== (c == last) || busy !== (c <= last) ||
             err !== 1'b0 || remaining !== to_bcd(n - k) ||
             sent !== (SENT_EN ? 16'(k) : 16'h0)) begin
            n_fail++;
            errs++;
            $display("FAIL run_n%0d_c%0d: pulse=%b busy=%b done=%b err=%b rem=%h sent=%0d, required pulse=%b busy=%b done=%b err=0 rem=%h sent=%0d",
                     n, c, pulse_out, busy, done, err, remaining, sent,
                     model_pulse(n, c), (c <= last), (c == last), to_bcd(n - k),
                     SENT_EN ? k : 0);
         end
      end
      $display("[TB] run n=%0d: %0d cycles, %0d errors", n, last + 1, errs);
   endtask

   task automatic test_nominal;
      test_run(3);
   endtask

   task automatic test_borrow;
      start_run(16'h1000);
      for (int c = 1; c <= 11; c++) begin
         @(negedge clk);
         if (c == 3) begin
            n_tests++;
            if (remaining !== 16'h0999) begin
               n_fail++;
               $display("FAIL borrow_first: rem=%h, required 0999", remaining);
            end
         end
         if (c == 11) begin
            n_tests++;
            if (remaining !== 16'h0998) begin
               n_fail++;
               $display("FAIL borrow_second: rem=%h, required 0998", remaining);
            end
            abort = 1'b1;
         end
      end
      @(posedge clk); #1;
      abort = 1'b0;
      @(negedge clk);
      n_tests++;
      if (busy !== 1'b0 || remaining !== 16'h0998) begin
         n_fail++;
         $display("FAIL borrow_abort: busy=%b rem=%h, required busy=0 rem=0998", busy, remaining);
      end
      $display("[TB] borrow: 1000 -> 0999 -> 0998 checked");
   endtask

   task automatic test_reject;
      logic [15:0] rem_before;
      rem_before = remaining;
      start_run(16'h00A1);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         n_tests++;
         if (err !== (c == 1) || busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0 ||
             remaining !== rem_before) begin
            n_fail++;
            $display("FAIL reject_c%0d: err=%b busy=%b pulse=%b done=%b rem=%h, required err=%b busy=0 pulse=0 done=0 rem=%h",
                     c, err, busy, pulse_out, done, remaining, (c == 1), rem_before);
         end
      end
      $display("[TB] reject: bcd_in=00A1 checked");
   endtask

   task automatic test_empty;
      start_run(16'h0000);
      for (int c = 1; c <= 4; c++) begin
         @(negedge clk);
         n_tests++;
         if (done !== (c == 1) || pulse_out !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL empty_c%0d: done=%b pulse=%b err=%b, required done=%b pulse=0 err=0",
                     c, done, pulse_out, err, (c == 1));
         end
      end
      $display("[TB] empty: bcd_in=0000 checked");
   endtask

   // Abort during the GAP after pulse p; start is raised in the same cycle and must be ignored.
   task automatic abort_scenario(input int n, input int p, input int gap_cycle, input string name);
      int stop_c;
      int errs;
      errs = 0;
      stop_c = (p - 1) * TD + PH + gap_cycle;
      start_run(to_bcd(n));
      for (int c = 1; c <= stop_c; c++) begin
         @(negedge clk);
         n_tests++;
         if (pulse_out !== model_pulse(n, c) || done !== 1'b0) begin
            n_fail++;
            errs++;
            $display("FAIL %s_c%0d: pulse=%b done=%b, required pulse=%b done=0",
                     name, c, pulse_out, done, model_pulse(n, c));
         end
      end
      abort  = 1'b1;
      start  = 1'b1;
      bcd_in = 16'h0007;
      @(posedge clk); #1;
      abort = 1'b0;
      start = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         n_tests++;
         if (busy !== 1'b0 || pulse_out !== 1'b0 || done !== 1'b0 || remaining !== to_bcd(n - p) ||
             sent !== (SENT_EN ? 16'(p) : 16'h0)) begin
            n_fail++;
            errs++;
            $display("FAIL %s_after%0d: busy=%b pulse=%b done=%b rem=%h sent=%0d, required busy=0 pulse=0 done=0 rem=%h sent=%0d",
                     name, c, busy, pulse_out, done, remaining, sent, to_bcd(n - p), SENT_EN ? p : 0);
         end
      end
      $display("[TB] %s: n=%0d aborted after %0d pulses, %0d errors", name, n, p, errs);
   endtask

   task automatic test_abort;
      abort_scenario(5, 2, 2, "abort");
   endtask

   task automatic test_random_abort;
      int d;
      for (int i = 0; i < 6; i++) begin
         d = from_bcd(to_bcd($urandom_range(0, 9999)));
         if (d < 4) d += 4;
         abort_scenario(d, $urandom_range(1, 3), $urandom_range(1, TD - PH), "rand_abort");
      end
   endtask

   task automatic test_random_runs;
      for (int i = 0; i < 4; i++) begin
         test_run($urandom_range(1, 5));
      end
   endtask

   task automatic test_reset_mid_pulse;
      start_run(16'h0003);
      @(negedge clk);
      n_tests++;
      if (pulse_out !== 1'b1) begin
         n_fail++;
         $display("FAIL midreset_pre: pulse=%b, required 1", pulse_out);
      end
      #1 reset = 1'b1;
      #1;
      n_tests++;
      if (pulse_out !== 1'b0 || busy !== 1'b0 || remaining !== 16'h0) begin
         n_fail++;
         $display("FAIL midreset_async: pulse=%b busy=%b rem=%h, required 0 0 0000",
                  pulse_out, busy, remaining);
      end
      @(negedge clk);
      reset = 1'b0;
      $display("[TB] reset mid-pulse: async clear checked");
      test_run(2);
   endtask

   initial begin
      test_reset();
      test_nominal();
      test_borrow();
      test_reject();
      test_empty();
      test_abort();
      test_random_abort();
      test_random_runs();
      test_reset_mid_pulse();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
